// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: FSM states, control-bit positions
// inside the WB/Mem control fields, and the default datapath width.
package cpu_pkg;

  localparam int DEF_DATA_W = 32;

  // WB control field bit positions
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  // Mem control field bit positions
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A load captures everything, a squash keeps the
// ALU result and rd but kills WB control, and otherwise a bubble clears WB control.
module mem_wb_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              squash,
  input  logic [1:0]        wb_in,
  input  logic [DATA_W-1:0] rdata_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [4:0]        rd_in,
  output logic [1:0]        wb_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [4:0]        rd_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_out    <= '0;
      rdata_out <= '0;
      alu_out   <= '0;
      rd_out    <= '0;
    end else if (load) begin
      wb_out    <= wb_in;
      rdata_out <= rdata_in;
      alu_out   <= alu_in;
      rd_out    <= rd_in;
    end else if (squash) begin
      wb_out    <= '0;
      rdata_out <= '0;
      alu_out   <= alu_in;
      rd_out    <= rd_in;
    end else begin
      // bubble: only WB control is killed, the data fields hold
      wb_out    <= '0;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues the data-memory req/ack transaction, stalls the
// upstream pipeline while an access is outstanding, and loads the MEM/WB register.
module mem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        wb_in,
  input  logic [1:0]        mem_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] store_in,
  input  logic [4:0]        rd_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic [1:0]        wb_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [4:0]        rd_out,
  output logic              align_err,
  output logic              bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            state;
  state_t            state_nx;
  logic [7:0]        cnt;
  logic              access;
  logic              is_write;
  logic              misaligned;
  logic              timeout_hit;
  logic              issue;
  logic              load;
  logic              squash;
  logic              align_nx;
  logic              bus_nx;
  logic [DATA_W-1:0] rdata_sel;

  assign access      = mem_in[MEMREAD] | mem_in[MEMWRITE];
  assign is_write    = mem_in[MEMWRITE];
  assign misaligned  = access && (alu_in[1:0] != 2'b00);
  assign timeout_hit = (state == WAIT) && (cnt == CNT_LAST);
  // a completing write returns no load data
  assign rdata_sel   = ((state == WAIT) && !dmem_we) ? dmem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    load     = 1'b0;
    squash   = 1'b0;
    align_nx = 1'b0;
    bus_nx   = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (!access) begin
          load = 1'b1;
        end else if (misaligned) begin
          squash   = 1'b1;
          align_nx = 1'b1;
        end else begin
          issue    = 1'b1;
          stall    = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // ack takes priority over a timeout in the same cycle
        if (dmem_ack) begin
          load     = 1'b1;
          state_nx = IDLE;
        end else if (timeout_hit) begin
          bus_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          stall    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cnt        <= '0;
      align_err  <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      align_err <= align_nx;
      bus_err   <= bus_nx;
      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= is_write;
        dmem_addr  <= alu_in;
        dmem_wdata <= store_in;
        cnt        <= '0;
      end else if (state == WAIT) begin
        if (state_nx == IDLE) dmem_req <= 1'b0;
        else                  cnt      <= sat_inc(cnt);
      end
    end
  end

  mem_wb_reg #(
    .DATA_W(DATA_W)
  ) u_mem_wb (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .squash   (squash),
    .wb_in    (wb_in),
    .rdata_in (rdata_sel),
    .alu_in   (alu_in),
    .rd_in    (rd_in),
    .wb_out   (wb_out),
    .rdata_out(rdata_out),
    .alu_out  (alu_out),
    .rd_out   (rd_out)
  );

endmodule
